// File: rtl/vid_pkg.sv
// Shared types and constants for the video timing generator: pixel type,
// pattern mode codes, the colour-bar table and the aligned control word.
package vid_pkg;

  typedef logic [23:0] rgb_t;

  localparam logic [1:0] MODE_IMAGE = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_RAMP  = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  // Control and pattern colour for one pixel position, carried down the delay line.
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       win;
    logic       fs;
    logic [1:0] mode;
    rgb_t       pat;
  } vid_ctrl_t;

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vid_delay_line.sv
// Width x depth shift register with synchronous active-low clear.
module vid_delay_line #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe_q [D];
  logic [W-1:0] pipe_d [D];

  always_comb begin
    pipe_d[0] = d;
    for (int i = 1; i < D; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < D; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign q = pipe_q[D-1];

endmodule

// File: rtl/vid_timing_gen.sv
// Parametrised CEA-style timing generator with image window, read-ahead
// request to the image source, test patterns and a frame counter.
module vid_timing_gen
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int IMG_X    = 320,
  parameter int IMG_Y    = 180,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 360,
  parameter int RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic [23:0] border_rgb,
  input  logic [23:0] rd_data,
  output logic        rd_req,
  output logic        vpg_de,
  output logic        vpg_hs,
  output logic        vpg_vs,
  output logic [23:0] rgb,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam logic [15:0] H_LAST    = 16'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [15:0] V_LAST    = 16'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [15:0] H_ACT_BEG = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_ACT_END = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] V_ACT_BEG = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_ACT_END = 16'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [15:0] H_WIN_BEG = 16'(H_SYNC + H_BP + IMG_X);
  localparam logic [15:0] H_WIN_END = 16'(H_SYNC + H_BP + IMG_X + IMG_W);
  localparam logic [15:0] V_WIN_BEG = 16'(V_SYNC + V_BP + IMG_Y);
  localparam logic [15:0] V_WIN_END = 16'(V_SYNC + V_BP + IMG_Y + IMG_H);
  localparam logic [15:0] HS_END    = 16'(H_SYNC);
  localparam logic [15:0] VS_END    = 16'(V_SYNC);
  localparam logic [15:0] BAR_LAST  = 16'(H_ACTIVE / 8 - 1);
  localparam logic        HS_ACT    = (HS_POL != 0);
  localparam logic        VS_ACT    = (VS_POL != 0);

  logic [15:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [15:0] bar_sub_q, bar_sub_d, frame_cnt_q, frame_cnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [1:0]  mode_q, mode_d;
  logic        rd_req_q, rd_req_d;
  logic        h_wrap, act, win;
  logic [7:0]  x_lo;
  vid_ctrl_t   ctrl_in, ctrl_out;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? 16'd0 : h_cnt_q + 16'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = (v_cnt_q == V_LAST) ? 16'd0 : v_cnt_q + 16'd1;
    mode_d = (h_cnt_q == 16'd0 && v_cnt_q == 16'd0) ? mode : mode_q;

    act = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END) &&
          (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
    win = act && (h_cnt_q >= H_WIN_BEG) && (h_cnt_q < H_WIN_END) &&
          (v_cnt_q >= V_WIN_BEG) && (v_cnt_q < V_WIN_END);
    x_lo = h_cnt_q[7:0] - H_ACT_BEG[7:0];

    // Bar state describes the current h_cnt; it is reloaded on the edge into x = 0.
    bar_sub_d = bar_sub_q + 16'd1;
    bar_idx_d = bar_idx_q;
    if (h_cnt_d == H_ACT_BEG) begin
      bar_sub_d = 16'd0;
      bar_idx_d = 3'd0;
    end else if (bar_sub_q == BAR_LAST) begin
      bar_sub_d = 16'd0;
      bar_idx_d = bar_idx_q + 3'd1;
    end

    ctrl_in      = '0;
    ctrl_in.de   = act;
    ctrl_in.hs   = (h_cnt_q < HS_END);
    ctrl_in.vs   = (v_cnt_q < VS_END);
    ctrl_in.win  = win;
    ctrl_in.fs   = (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
    ctrl_in.mode = mode_q;
    ctrl_in.pat  = (mode_q == MODE_BARS) ? bar_colour(bar_idx_q) : {3{x_lo}};

    rd_req_d    = win && (mode_q == MODE_IMAGE);
    frame_cnt_d = frame_cnt_q + {15'd0, ctrl_out.fs};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      bar_sub_q   <= '0;
      bar_idx_q   <= '0;
      mode_q      <= MODE_IMAGE;
      rd_req_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      bar_sub_q   <= bar_sub_d;
      bar_idx_q   <= bar_idx_d;
      mode_q      <= mode_d;
      rd_req_q    <= rd_req_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // One extra stage beyond RD_LAT so rd_data lands in the same cycle as its pixel.
  vid_delay_line #(
    .W ($bits(vid_ctrl_t)),
    .D (RD_LAT + 1)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ctrl_in),
    .q     (ctrl_out)
  );

  always_comb begin
    rgb = 24'h0;
    if (ctrl_out.de) begin
      case (ctrl_out.mode)
        MODE_IMAGE: rgb = ctrl_out.win ? rd_data : border_rgb;
        MODE_SOLID: rgb = border_rgb;
        default:    rgb = ctrl_out.pat;
      endcase
    end
  end

  assign rd_req      = rd_req_q;
  assign vpg_de      = ctrl_out.de;
  assign vpg_hs      = ~(ctrl_out.hs ^ HS_ACT);
  assign vpg_vs      = ~(ctrl_out.vs ^ VS_ACT);
  assign frame_start = ctrl_out.fs;
  assign frame_cnt   = frame_cnt_q;

endmodule
